gshare_branch_predictor: RTL and testbench

//  Decode-stage dynamic branch predictor for the torv32 5-stage pipeline; replaces static not-taken.

---
 rtl/gshare_branch_predictor_pkg.sv | 40 ++++
 rtl/gshare_branch_predictor_if.sv | 30 +++
 rtl/gshare_branch_predictor_bht_table.sv | 49 ++++
 rtl/gshare_branch_predictor.sv | 127 ++++++++++++
 tb/tb_gshare_branch_predictor.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/gshare_branch_predictor_pkg.sv
// Shared definitions for the gshare predictor: opcodes, 2-bit counter
// encodings, FSM states and the immediate extractors that imm_mux also uses.
package gshare_branch_predictor_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // 2-bit saturating counter states; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // B-type immediate, sign-extended, bit 0 always zero.
    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended, bit 0 always zero.
    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

    // Next counter value: step toward taken/not-taken, saturating at ST/SNT.
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == ST)  ? ST  : c + 2'd1;
        else
            return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Decode-side prediction and execute-side training signals of the predictor.
// The pipeline is the master; the predictor is the slave.
interface gshare_branch_predictor_if #(
    parameter int IDX_BITS = 8
) ();

    logic                d_valid;
    logic                d_stall;
    logic [31:0]         d_IR;
    logic [31:0]         d_PC;
    logic                p_taken;
    logic [31:0]         p_target;
    logic [IDX_BITS-1:0] p_idx;
    logic                ready;
    logic                e_update;
    logic                e_taken;
    logic                e_pred;
    logic [IDX_BITS-1:0] e_idx;

    modport master (
        output d_valid, d_stall, d_IR, d_PC, e_update, e_taken, e_pred, e_idx,
        input  p_taken, p_target, p_idx, ready
    );

    modport slave (
        input  d_valid, d_stall, d_IR, d_PC, e_update, e_taken, e_pred, e_idx,
        output p_taken, p_target, p_idx, ready
    );

endinterface

// File: rtl/gshare_branch_predictor_bht_table.sv
// Branch history table: 2**IDX_BITS two-bit counters with an asynchronous
// prediction read port and one synchronous write port shared between the
// initialisation sweep and the saturating training update.
module bht_table
    import gshare_branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 8
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                init_we,
    input  logic [IDX_BITS-1:0] init_idx,
    input  logic [1:0]          init_val,
    input  logic                upd_we,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int DEPTH = 2 ** IDX_BITS;

    logic [1:0]          mem [DEPTH];
    logic                wr_en;
    logic [IDX_BITS-1:0] wr_idx;
    logic [1:0]          wr_val;

    // Prediction read is combinational so a same-cycle update is seen only after the edge.
    assign rd_ctr = mem[rd_idx];

    // Select the write source: the init sweep wins, otherwise the saturating update.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_en  = init_we | upd_we;
        wr_idx = upd_idx;
        wr_val = ctr_next(mem[upd_idx], upd_taken);
        if (init_we) begin
            wr_idx = init_idx;
            wr_val = init_val;
        end
    end

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the INIT sweep rewrites every entry before ready rises.
        if (wr_en)
            mem[wr_idx] <= wr_val;
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Decode-stage gshare branch predictor. Indexes a table of 2-bit counters
// with PC xor global history (bimodal when HIST_BITS=0), predicts B-type and
// JAL redirects with zero latency, trains from execute and keeps hit stats.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int IDX_BITS  = 8,
    parameter int HIST_BITS = 8,
    parameter int CNT_INIT  = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    gshare_branch_predictor_if.slave bus,
    output logic [31:0]              nb_branch,
    output logic [31:0]              nb_hit
);

    state_e              state;
    logic                ready_q;
    logic [IDX_BITS-1:0] init_ptr;
    logic [IDX_BITS-1:0] hist_idx;
    logic [IDX_BITS-1:0] idx;
    logic [1:0]          rd_ctr;
    logic                init_we;
    logic                run_upd;
    logic [31:0]         target;
    logic                unused_d_stall;

    // Outputs follow the held d_IR/d_PC, so a decode stall needs no handling here.
    assign unused_d_stall = bus.d_stall;

    // Writes are gated by resetn so a training pulse during reset never lands.
    assign init_we = resetn && (state == S_INIT);
    assign run_upd = resetn && (state == S_RUN) && bus.e_update;

    // Sweep every table entry after reset, then enter RUN with ready registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!resetn) begin
            state    <= S_INIT;
            init_ptr <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_ptr <= init_ptr + IDX_BITS'(1);
                    if (init_ptr == '1) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN:   ready_q <= 1'b1;
                default: state   <= S_INIT;
            endcase
        end
    end

    if (HIST_BITS > 0) begin : g_hist
        logic [HIST_BITS-1:0] history;

        // Non-speculative global history: shift in each resolved outcome.
        always_ff @(posedge clk) begin
            if (!resetn)
                history <= '0;
            else if (run_upd)
                history <= HIST_BITS'({history, bus.e_taken});
        end

        // History is aligned to the top of the index.
        assign hist_idx = IDX_BITS'(history) << (IDX_BITS - HIST_BITS);
    end else begin : g_bimodal
        assign hist_idx = '0;
    end

    assign idx       = bus.d_PC[IDX_BITS+1:2] ^ hist_idx;
    assign bus.p_idx = idx;
    assign bus.ready = ready_q;

    bht_table #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk       (clk),
        .rd_idx    (idx),
        .rd_ctr    (rd_ctr),
        .init_we   (init_we),
        .init_idx  (init_ptr),
        .init_val  (2'(CNT_INIT)),
        .upd_we    (run_upd),
        .upd_idx   (bus.e_idx),
        .upd_taken (bus.e_taken)
    );

    // Decode the instruction in decode and form direction and redirect target.
    always_comb begin
        bus.p_taken = 1'b0;
        target      = bus.d_PC + 32'd4;
        if (ready_q && bus.d_valid) begin
            case (bus.d_IR[6:0])
                OP_JAL: begin
                    bus.p_taken = 1'b1;
                    target      = bus.d_PC + imm_j(bus.d_IR);
                end
                OP_BRANCH: begin
                    bus.p_taken = rd_ctr[1];
                    target      = bus.d_PC + imm_b(bus.d_IR);
                end
                OP_JALR: ;
                default: ;
            endcase
        end
    end

    assign bus.p_target = target & ~32'd1;

    // Resolved-branch statistics; reset clears them, the INIT sweep does not.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            nb_branch <= '0;
            nb_hit    <= '0;
        end else if (run_upd) begin
            nb_branch <= nb_branch + 32'd1;
            if (bus.e_pred == bus.e_taken)
                nb_hit <= nb_hit + 32'd1;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor. Three instances share clock
// and reset: A = gshare (HIST_BITS=8), B = gshare (HIST_BITS=2),
// C = bimodal (HIST_BITS=0). Expected values are hand-computed constants.
module tb_gshare_branch_predictor;

    logic clk;
    logic resetn;
    logic [31:0] nbb_a, nbh_a, nbb_b, nbh_b, nbb_c, nbh_c;

    int n_total = 0;
    int n_pass  = 0;

    gshare_branch_predictor_if #(.IDX_BITS(8)) ifa ();
    gshare_branch_predictor_if #(.IDX_BITS(8)) ifb ();
    gshare_branch_predictor_if #(.IDX_BITS(8)) ifc ();

    gshare_branch_predictor #(.IDX_BITS(8), .HIST_BITS(8), .CNT_INIT(1)) dut_a (
        .clk(clk), .resetn(resetn), .bus(ifa), .nb_branch(nbb_a), .nb_hit(nbh_a)
    );
    gshare_branch_predictor #(.IDX_BITS(8), .HIST_BITS(2), .CNT_INIT(1)) dut_b (
        .clk(clk), .resetn(resetn), .bus(ifb), .nb_branch(nbb_b), .nb_hit(nbh_b)
    );
    gshare_branch_predictor #(.IDX_BITS(8), .HIST_BITS(0), .CNT_INIT(1)) dut_c (
        .clk(clk), .resetn(resetn), .bus(ifc), .nb_branch(nbb_c), .nb_hit(nbh_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    localparam logic [31:0] JALR_IR = {12'h000, 5'd1, 3'b000, 5'd1, 7'b1100111};
    localparam logic [31:0] ADDI_IR = 32'h0000_0013;

    // Train instance C at index 0x40 with a given outcome (e_pred fixed at 0).
    task automatic upd_c(input logic taken);
        ifc.e_update = 1'b1;
        ifc.e_taken  = taken;
        ifc.e_pred   = 1'b0;
        ifc.e_idx    = 8'h40;
        @(posedge clk);
        #1;
        ifc.e_update = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        int init_bad;
        logic [31:0] base_hit_b, base_br_b, base_hit_c, base_br_c;
        logic outcome;

        resetn = 1'b0;
        ifa.d_valid = 1'b1; ifa.d_stall = 1'b0; ifa.d_PC = 32'h40; ifa.d_IR = enc_j(21'h800);
        ifa.e_update = 1'b0; ifa.e_taken = 1'b0; ifa.e_pred = 1'b0; ifa.e_idx = '0;
        ifb.d_valid = 1'b1; ifb.d_stall = 1'b0; ifb.d_PC = 32'h40; ifb.d_IR = enc_j(21'h800);
        ifb.e_update = 1'b0; ifb.e_taken = 1'b0; ifb.e_pred = 1'b0; ifb.e_idx = '0;
        ifc.d_valid = 1'b1; ifc.d_stall = 1'b0; ifc.d_PC = 32'h40; ifc.d_IR = enc_j(21'h800);
        ifc.e_update = 1'b0; ifc.e_taken = 1'b0; ifc.e_pred = 1'b0; ifc.e_idx = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ifa.ready}, 32'd0);
        check("reset_nb_branch", nbb_a, 32'd0);
        check("reset_p_taken", {31'd0, ifa.p_taken}, 32'd0);
        check("reset_p_target", ifa.p_target, 32'h44);

        // INIT takes 256 cycles; a JAL is presented throughout and must not redirect.
        resetn = 1'b1;
        n = 0;
        init_bad = 0;
        while (!ifa.ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (!ifa.ready && (ifa.p_taken !== 1'b0)) init_bad++;
        end
        check("ready_latency", 32'(n), 32'd256);
        check("init_p_taken", 32'(init_bad), 32'd0);
        check("ready_b", {31'd0, ifb.ready}, 32'd1);
        check("ready_c", {31'd0, ifc.ready}, 32'd1);

        // JAL / JALR / invalid / non-branch on instance A.
        check("jal_taken", {31'd0, ifa.p_taken}, 32'd1);
        check("jal_target", ifa.p_target, 32'h840);
        ifa.d_IR = JALR_IR; #1;
        check("jalr_taken", {31'd0, ifa.p_taken}, 32'd0);
        check("jalr_target", ifa.p_target, 32'h44);
        ifa.d_IR = enc_j(21'h800); ifa.d_valid = 1'b0; #1;
        check("invalid_taken", {31'd0, ifa.p_taken}, 32'd0);
        check("invalid_target", ifa.p_target, 32'h44);
        ifa.d_valid = 1'b1; ifa.d_IR = ADDI_IR; #1;
        check("other_taken", {31'd0, ifa.p_taken}, 32'd0);

        // Gshare index: PC 0x100 -> 0x40 with empty history, 0x41 after one taken.
        ifa.d_PC = 32'h100; ifa.d_IR = enc_b(13'h1FF8); #1;
        check("a_idx_h0", 32'(ifa.p_idx), 32'h40);
        check("a_btaken_h0", {31'd0, ifa.p_taken}, 32'd0);
        check("a_btarget", ifa.p_target, 32'hF8);
        ifa.e_update = 1'b1; ifa.e_taken = 1'b1; ifa.e_pred = 1'b0; ifa.e_idx = 8'h40;
        @(posedge clk);
        #1;
        ifa.e_update = 1'b0;
        #1;
        check("a_idx_h1", 32'(ifa.p_idx), 32'h41);
        check("a_btaken_h1", {31'd0, ifa.p_taken}, 32'd0);
        check("a_nb_branch", nbb_a, 32'd1);
        check("a_nb_hit", nbh_a, 32'd0);

        // Bimodal counter walk on instance C, PC 0x100 -> entry 0x40, starts WNT.
        ifc.d_PC = 32'h100; ifc.d_IR = enc_b(13'h1FF8); #1;
        check("c_idx", 32'(ifc.p_idx), 32'h40);
        check("c_taken_wnt", {31'd0, ifc.p_taken}, 32'd0);
        check("c_target", ifc.p_target, 32'hF8);
        ifc.e_update = 1'b1; ifc.e_taken = 1'b1; ifc.e_pred = 1'b0; ifc.e_idx = 8'h40; #1;
        check("c_read_before_write", {31'd0, ifc.p_taken}, 32'd0);
        @(posedge clk);
        #1;
        ifc.e_update = 1'b0;
        #1;
        check("c_taken_after_1T", {31'd0, ifc.p_taken}, 32'd1);
        upd_c(1'b1); upd_c(1'b1); upd_c(1'b1);
        upd_c(1'b0);
        check("c_sat3_then_N", {31'd0, ifc.p_taken}, 32'd1);
        upd_c(1'b0);
        check("c_second_N", {31'd0, ifc.p_taken}, 32'd0);
        upd_c(1'b0); upd_c(1'b0); upd_c(1'b0);
        upd_c(1'b1);
        check("c_sat0_then_T", {31'd0, ifc.p_taken}, 32'd0);
        upd_c(1'b1);
        check("c_second_T", {31'd0, ifc.p_taken}, 32'd1);
        check("c_nb_branch", nbb_c, 32'd11);
        check("c_nb_hit", nbh_c, 32'd5);

        // Loop T,T,N x30 at PC 0x200 on B (gshare, 2-bit history) and C (bimodal).
        ifb.d_PC = 32'h200; ifb.d_IR = enc_b(13'h1FF8);
        ifc.d_PC = 32'h200; ifc.d_IR = enc_b(13'h1FF8);
        #1;
        base_hit_b = '0; base_br_b = '0; base_hit_c = '0; base_br_c = '0;
        for (int i = 0; i < 90; i++) begin
            if (i == 75) begin
                base_hit_b = nbh_b; base_br_b = nbb_b;
                base_hit_c = nbh_c; base_br_c = nbb_c;
            end
            outcome = (i % 3) != 2;
            ifb.e_update = 1'b1; ifb.e_taken = outcome; ifb.e_pred = ifb.p_taken; ifb.e_idx = ifb.p_idx;
            ifc.e_update = 1'b1; ifc.e_taken = outcome; ifc.e_pred = ifc.p_taken; ifc.e_idx = ifc.p_idx;
            @(posedge clk);
            #1;
        end
        ifb.e_update = 1'b0;
        ifc.e_update = 1'b0;
        #1;
        check("b_loop_branches", nbb_b - base_br_b, 32'd15);
        check("b_loop_hits", nbh_b - base_hit_b, 32'd15);
        check("c_loop_branches", nbb_c - base_br_c, 32'd15);
        check("c_loop_hits", nbh_c - base_hit_c, 32'd10);

        // One-cycle reset mid-RUN with a training pulse on A; INIT then reruns in full.
        ifc.d_PC = 32'h100;
        ifa.d_PC = 32'h100; ifa.d_IR = enc_b(13'h1FF8);
        ifa.e_update = 1'b1; ifa.e_taken = 1'b1; ifa.e_pred = 1'b1; ifa.e_idx = 8'h41;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check("rst2_ready", {31'd0, ifa.ready}, 32'd0);
        check("rst2_nb_branch", nbb_a, 32'd0);
        check("rst2_idx", 32'(ifa.p_idx), 32'h40);
        check("rst2_c_nb_branch", nbb_c, 32'd0);
        n = 0;
        while (!ifa.ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        ifa.e_update = 1'b0;
        #1;
        check("rst2_latency", 32'(n), 32'd256);
        check("rst2_run_nb_branch", nbb_a, 32'd0);
        check("rst2_run_nb_hit", nbh_a, 32'd0);
        check("rst2_run_idx", 32'(ifa.p_idx), 32'h40);
        check("rst2_a_reinit", {31'd0, ifa.p_taken}, 32'd0);
        check("rst2_c_reinit", {31'd0, ifc.p_taken}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
